// File: rtl/bin_bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// controller state encoding, BCD digit type, bit-counter width and the
// digit-count helper that sizes the BCD result.
package bin_bcd_pkg;

   // Controller states of the shift-and-add-3 sequencer
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // One packed BCD digit
   typedef logic [3:0] bcd_digit_t;

   // Bit counter width; holds values up to 32 (largest legal BIN_W)
   localparam int CNT_W = 6;

   // Number of decimal digits needed to hold 2^w-1 (ceil(w*log10(2)))
   function automatic int bcd_digits(input int w);
      return (w * 32'sd301 + 32'sd999) / 32'sd1000;
   endfunction

endpackage : bin_bcd_pkg

// File: rtl/bcd_add3.sv
// Per-digit double-dabble correction cell: a digit of 5 or more gets +3
// so that the following left shift carries correctly into the next digit.
module bcd_add3
   import bin_bcd_pkg::*;
(
   input  bcd_digit_t i_digit,
   output bcd_digit_t o_digit
);

   // Add 3 when the digit would reach 10 or more after doubling
   always_comb begin
      o_digit = i_digit;
      if (i_digit >= 4'd5) begin
         o_digit = i_digit + 4'd3;
      end else begin
         o_digit = i_digit;
      end
   end

endmodule : bcd_add3

// File: rtl/bin_to_bcd.sv
// Sequential binary-to-BCD converter (double-dabble, one input bit per clock).
// A start pulse in IDLE captures bin_in; BIN_W SHIFT cycles follow, and the
// last shift loads bcd_out and raises done for one cycle (DONE state).
// Optional feature macro: BIN_BCD_SIGNED_EN -- bin_in is two's complement,
// its magnitude is converted and sign_out reports the sign with bcd_out.
module bin_to_bcd
   import bin_bcd_pkg::*;
#(
   parameter  int BIN_W  = 16,
   localparam int DIGITS = bcd_digits(BIN_W)
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin_in,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd_out
`ifdef BIN_BCD_SIGNED_EN
   ,
   output logic                  sign_out
`endif
);

   localparam int SCR_W = 4 * DIGITS;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [BIN_W-1:0]    r_shift;
   logic [BIN_W-1:0]    w_shift_nxt;
   logic [SCR_W-1:0]    r_scratch;
   logic [SCR_W-1:0]    w_scratch_nxt;
   logic [SCR_W-1:0]    w_corrected;
   logic [SCR_W-1:0]    w_shifted;
   logic [CNT_W-1:0]    r_count;
   logic [CNT_W-1:0]    w_count_nxt;
   logic                r_busy;
   logic                w_busy_nxt;
   logic                r_done;
   logic                w_done_nxt;
   logic [SCR_W-1:0]    r_bcd;
   logic [SCR_W-1:0]    w_bcd_nxt;
   logic [BIN_W-1:0]    w_operand;

`ifdef BIN_BCD_SIGNED_EN
   logic                r_neg;
   logic                w_neg_nxt;
   logic                r_sign;
   logic                w_sign_nxt;
   logic                w_in_neg;

   // Negative operands are converted as their magnitude; -2^(BIN_W-1)
   // wraps to 2^(BIN_W-1), which is exactly its unsigned magnitude
   assign w_in_neg  = bin_in[BIN_W-1];
   assign w_operand = w_in_neg ? ((~bin_in) + BIN_W'(1)) : bin_in;
   assign sign_out  = r_sign;
`else
   assign w_operand = bin_in;
`endif

   // One add-3 correction cell per BCD digit of the scratch register
   for (genvar g = 0; g < DIGITS; g++) begin : g_add3
      bcd_add3 u_add3 (
         .i_digit (r_scratch[4*g +: 4]),
         .o_digit (w_corrected[4*g +: 4])
      );
   end

   // Corrected scratch shifted left, taking in the next operand bit (MSB first);
   // the top bit never carries out because DIGITS covers 2^BIN_W-1
   assign w_shifted = SCR_W'({w_corrected, r_shift[BIN_W-1]});

   assign busy    = r_busy;
   assign done    = r_done;
   assign bcd_out = r_bcd;

   // Next-state and next-datapath logic of the conversion sequencer
   always_comb begin
      w_state_nxt   = r_state;
      w_shift_nxt   = r_shift;
      w_scratch_nxt = r_scratch;
      w_count_nxt   = r_count;
      w_busy_nxt    = r_busy;
      w_done_nxt    = 1'b0;
      w_bcd_nxt     = r_bcd;
`ifdef BIN_BCD_SIGNED_EN
      w_neg_nxt     = r_neg;
      w_sign_nxt    = r_sign;
`endif
      case (r_state)
         IDLE: begin
            if (start) begin
               w_state_nxt   = SHIFT;
               w_shift_nxt   = w_operand;
               w_scratch_nxt = {SCR_W{1'b0}};
               w_count_nxt   = CNT_W'(BIN_W);
               w_busy_nxt    = 1'b1;
`ifdef BIN_BCD_SIGNED_EN
               w_neg_nxt     = w_in_neg;
`endif
            end else begin
               w_state_nxt   = IDLE;
               w_busy_nxt    = 1'b0;
            end
         end
         SHIFT: begin
            w_scratch_nxt = w_shifted;
            w_shift_nxt   = {r_shift[BIN_W-2:0], 1'b0};
            w_count_nxt   = r_count - CNT_W'(1);
            w_busy_nxt    = 1'b1;
            if (r_count == CNT_W'(1)) begin
               // Last shift: publish the finished result as DONE is entered
               w_state_nxt = DONE;
               w_done_nxt  = 1'b1;
               w_bcd_nxt   = w_shifted;
`ifdef BIN_BCD_SIGNED_EN
               w_sign_nxt  = r_neg;
`endif
            end else begin
               w_state_nxt = SHIFT;
            end
         end
         DONE: begin
            // start is ignored here; the requester must retry once busy drops
            w_state_nxt = IDLE;
            w_busy_nxt  = 1'b0;
         end
         default: begin
            w_state_nxt = IDLE;
            w_busy_nxt  = 1'b0;
         end
      endcase
   end

   // Sequencer and datapath registers; reset discards any conversion in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_shift   <= {BIN_W{1'b0}};
         r_scratch <= {SCR_W{1'b0}};
         r_count   <= {CNT_W{1'b0}};
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_bcd     <= {SCR_W{1'b0}};
      end else begin
         r_state   <= w_state_nxt;
         r_shift   <= w_shift_nxt;
         r_scratch <= w_scratch_nxt;
         r_count   <= w_count_nxt;
         r_busy    <= w_busy_nxt;
         r_done    <= w_done_nxt;
         r_bcd     <= w_bcd_nxt;
      end
   end

`ifdef BIN_BCD_SIGNED_EN
   // Captured operand sign and the sign reported alongside bcd_out
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_neg  <= 1'b0;
         r_sign <= 1'b0;
      end else begin
         r_neg  <= w_neg_nxt;
         r_sign <= w_sign_nxt;
      end
   end
`endif

endmodule : bin_to_bcd

// File: tb/tb_bin_to_bcd.sv
// Self-checking bench for bin_to_bcd (BIN_W=16, 5 digits). Expected digits
// come from decimal arithmetic (repeated /10 and %10) on the operand value.
module tb_bin_to_bcd;

   localparam int BW = 16;
   localparam int ND = 5;

   logic            clk;
   logic            rst;
   logic            start;
   logic [BW-1:0]   bin_in;
   logic            busy;
   logic            done;
   logic [4*ND-1:0] bcd_out;
`ifdef BIN_BCD_SIGNED_EN
   logic            sign_out;
`endif

   int errors;
   int checks;
   int done_cnt;
   logic [4*ND-1:0] prev_bcd;
   logic            prev_sign;

   bin_to_bcd #(.BIN_W(BW)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .bin_in  (bin_in),
      .busy    (busy),
      .done    (done),
      .bcd_out (bcd_out)
`ifdef BIN_BCD_SIGNED_EN
      ,
      .sign_out(sign_out)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count done pulses, sampled mid-cycle
   always @(negedge clk) begin
      if (done === 1'b1) done_cnt++;
   end

   // Magnitude of the operand as the converter interprets it
   function automatic int unsigned ref_mag(input logic [BW-1:0] v);
`ifdef BIN_BCD_SIGNED_EN
      if (v[BW-1]) return 32'd65536 - 32'(v);
      else         return 32'(v);
`else
      return 32'(v);
`endif
   endfunction

   function automatic logic ref_sign(input logic [BW-1:0] v);
`ifdef BIN_BCD_SIGNED_EN
      return v[BW-1];
`else
      return 1'b0;
`endif
   endfunction

   // Decimal digits of a value, units in the lowest nibble
   function automatic logic [4*ND-1:0] ref_bcd(input int unsigned mag);
      logic [4*ND-1:0] r;
      int unsigned m;
      r = '0;
      m = mag;
      for (int i = 0; i < ND; i++) begin
         r[4*i +: 4] = 4'(m % 32'd10);
         m = m / 32'd10;
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One conversion; poke=1 re-pulses start mid-busy, poke=2 pulses it during DONE
   task automatic convert(input logic [BW-1:0] v, input int poke, input string tag);
      int  cycles;
      bit  got;
      int  base;
      logic [4*ND-1:0] exp_bcd;
      base    = done_cnt;
      exp_bcd = ref_bcd(ref_mag(v));
      @(negedge clk);
      chk({tag, ".idle"}, 32'(busy), 32'd0);
      bin_in = v;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
      bin_in = BW'($urandom);
      chk({tag, ".busy_on"}, 32'(busy), 32'd1);
      cycles = 0;
      got    = 1'b0;
      while (!got && cycles < 40) begin
         if (poke == 1 && cycles == 5) begin
            start  = 1'b1;
            bin_in = BW'(9999);
         end else begin
            start  = 1'b0;
         end
         @(posedge clk);
         cycles++;
         #1;
         start = 1'b0;
         if (done === 1'b1) begin
            got = 1'b1;
         end else begin
            chk({tag, ".hold"}, 32'(bcd_out), 32'(prev_bcd));
            chk({tag, ".busy"}, 32'(busy), 32'd1);
         end
      end
      chk({tag, ".seen"}, 32'(got), 32'd1);
      chk({tag, ".lat"}, 32'(cycles), 32'(BW));
      chk({tag, ".bcd"}, 32'(bcd_out), 32'(exp_bcd));
`ifdef BIN_BCD_SIGNED_EN
      chk({tag, ".sign"}, 32'(sign_out), 32'(ref_sign(v)));
`endif
      if (poke == 2) begin
         start  = 1'b1;
         bin_in = BW'(4321);
      end else begin
         start  = 1'b0;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      chk({tag, ".done_off"}, 32'(done), 32'd0);
      chk({tag, ".busy_off"}, 32'(busy), 32'd0);
      chk({tag, ".ndone"}, 32'(done_cnt - base), 32'd1);
      prev_bcd  = exp_bcd;
      prev_sign = ref_sign(v);
      if (poke == 2) begin
         // The start offered during DONE must not have launched anything
         repeat (3) @(posedge clk);
         #1;
         chk({tag, ".no_restart"}, 32'(busy), 32'd0);
         chk({tag, ".bcd_kept"}, 32'(bcd_out), 32'(exp_bcd));
      end
   endtask

   initial begin
      int base;
      errors    = 0;
      checks    = 0;
      done_cnt  = 0;
      prev_bcd  = '0;
      prev_sign = 1'b0;
      rst       = 1'b1;
      start     = 1'b0;
      bin_in    = '0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.done", 32'(done), 32'd0);
      chk("rst.bcd", 32'(bcd_out), 32'd0);
`ifdef BIN_BCD_SIGNED_EN
      chk("rst.sign", 32'(sign_out), 32'd0);
`endif
      rst = 1'b0;

      // Directed conversions, including extremes and ignored starts
      convert(16'd0,     0, "zero");
      convert(16'd1234,  0, "v1234");
      convert(16'd65535, 0, "vmax");
      convert(16'd4095,  1, "busy_poke");
      convert(16'd9,     0, "b2b9");
      convert(16'd10,    0, "b2b10");
      convert(16'd32768, 2, "done_poke");
      convert(16'd32767, 0, "v32767");

      // Randomized operands
      for (int i = 0; i < 8; i++) begin
         convert(BW'($urandom), 0, $sformatf("rnd%0d", i));
      end

      // Asynchronous reset in the middle of SHIFT
      @(negedge clk);
      bin_in = 16'd54321;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (6) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst.busy", 32'(busy), 32'd0);
      chk("mid_rst.done", 32'(done), 32'd0);
      chk("mid_rst.bcd", 32'(bcd_out), 32'd0);
`ifdef BIN_BCD_SIGNED_EN
      chk("mid_rst.sign", 32'(sign_out), 32'd0);
`endif
      repeat (2) @(negedge clk);
      rst  = 1'b0;
      base = done_cnt;
      repeat (25) @(posedge clk);
      #1;
      chk("mid_rst.no_done", 32'(done_cnt - base), 32'd0);
      chk("mid_rst.idle", 32'(busy), 32'd0);
      prev_bcd  = '0;
      prev_sign = 1'b0;

      // Recovery after reset
      convert(16'd2024, 0, "after_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_bin_to_bcd
